// File: rtl/ether_frame_rx.sv
// Receive side of the 58-bit bit-banged Ethernet-PHY command link.
// The serial clock and data pins are oversampled with clk_in. One MSB-first
// frame is captured per start bit. The header, separators and trailer are
// checked, and the reg/data fields of each good frame are presented and held.
module ether_frame_rx #(
   parameter int          SEQ_LEN     = 58,
   parameter int          TIMEOUT_CYC = 4096,
   parameter logic [16:0] HDR_VAL     = 17'h03000
) (
   input  logic        clk_in,
   input  logic        reset_in,
   input  logic        sclk_in,
   input  logic        sdata_in,
   input  logic        rx_en,
   output logic        busy,
   output logic        frame_valid,
   output logic [15:0] frame_reg,
   output logic [15:0] frame_data,
   output logic        frame_err,
   output logic [2:0]  err_code,
   output logic [15:0] frame_cnt
);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_SHIFT     = 2'd1;
   localparam logic [1:0] ST_CHECK     = 2'd2;
   localparam logic [1:0] ST_WAIT_IDLE = 2'd3;

   localparam logic [5:0]  LAST_BIT = 6'(SEQ_LEN - 1);
   localparam logic [12:0] TIMER_TC = 13'(TIMEOUT_CYC - 1);

   localparam logic [2:0] ERR_HDR     = 3'd1;
   localparam logic [2:0] ERR_SEP     = 3'd2;
   localparam logic [2:0] ERR_TRAILER = 3'd3;
   localparam logic [2:0] ERR_TIMEOUT = 3'd4;

   logic [2:0]         sclk_sync_q, sclk_sync_d;
   logic [1:0]         sdata_sync_q, sdata_sync_d;
   logic [1:0]         state_q, state_d;
   logic [SEQ_LEN-1:0] shift_q, shift_d;
   logic [5:0]         bit_cnt_q, bit_cnt_d;
   logic [12:0]        timer_q, timer_d;
   logic               frame_valid_q, frame_valid_d;
   logic               frame_err_q, frame_err_d;
   logic [2:0]         err_code_q, err_code_d;
   logic [15:0]        frame_reg_q, frame_reg_d;
   logic [15:0]        frame_data_q, frame_data_d;
   logic [15:0]        frame_cnt_q, frame_cnt_d;

   logic        strobe;
   logic        sample_bit;
   logic [12:0] timer_next;

   // The third sclk flop only serves the rising-edge detect. The strobe is
   // combinational, so its effect lands on the third clk_in edge after the pin moves.
   assign strobe     = sclk_sync_q[1] & ~sclk_sync_q[2];
   assign sample_bit = sdata_sync_q[1];
   assign timer_next = timer_q + 13'd1;

   assign busy        = (state_q == ST_SHIFT) || (state_q == ST_CHECK);
   assign frame_valid = frame_valid_q;
   assign frame_err   = frame_err_q;
   assign err_code    = err_code_q;
   assign frame_reg   = frame_reg_q;
   assign frame_data  = frame_data_q;
   assign frame_cnt   = frame_cnt_q;

   // Shift the asynchronous pins into the synchronizer chains
   always_comb begin
      sclk_sync_d  = {sclk_sync_q[1:0], sclk_in};
      sdata_sync_d = {sdata_sync_q[0], sdata_in};
   end

   // Frame capture FSM, inter-strobe timeout and the checker for the result
   always_comb begin
      state_d       = state_q;
      shift_d       = shift_q;
      bit_cnt_d     = bit_cnt_q;
      timer_d       = timer_q;
      frame_valid_d = 1'b0;
      frame_err_d   = 1'b0;
      err_code_d    = err_code_q;
      frame_reg_d   = frame_reg_q;
      frame_data_d  = frame_data_q;
      frame_cnt_d   = frame_cnt_q;

      if (!rx_en) begin
         state_d   = ST_IDLE;
         bit_cnt_d = 6'd0;
         timer_d   = 13'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (strobe && !sample_bit) begin
                  state_d   = ST_SHIFT;
                  shift_d   = {{(SEQ_LEN-1){1'b0}}, sample_bit};
                  bit_cnt_d = 6'd1;
                  timer_d   = 13'd0;
               end
            end
            ST_SHIFT: begin
               if (strobe) begin
                  shift_d   = {shift_q[SEQ_LEN-2:0], sample_bit};
                  bit_cnt_d = bit_cnt_q + 6'd1;
                  timer_d   = 13'd0;
                  if (bit_cnt_q == LAST_BIT) begin
                     state_d = ST_CHECK;
                  end
               end else if (timer_next == TIMER_TC) begin
                  // The timeout fires as the counter reaches terminal count. The
                  // pulse then lands TIMEOUT_CYC cycles after the last strobe.
                  state_d     = ST_WAIT_IDLE;
                  timer_d     = 13'd0;
                  frame_err_d = 1'b1;
                  err_code_d  = ERR_TIMEOUT;
               end else begin
                  timer_d = timer_next;
               end
            end
            ST_CHECK: begin
               state_d = ST_WAIT_IDLE;
               if (shift_q[57:41] != HDR_VAL) begin
                  frame_err_d = 1'b1;
                  err_code_d  = ERR_HDR;
               end else if ((shift_q[40:39] != 2'b11) || (shift_q[22:21] != 2'b11)) begin
                  frame_err_d = 1'b1;
                  err_code_d  = ERR_SEP;
               end else if (shift_q[4:0] != 5'b11000) begin
                  frame_err_d = 1'b1;
                  err_code_d  = ERR_TRAILER;
               end else begin
                  frame_valid_d = 1'b1;
                  frame_reg_d   = shift_q[38:23];
                  frame_data_d  = shift_q[20:5];
                  frame_cnt_d   = frame_cnt_q + 16'd1;
               end
            end
            default: begin
               // Re-arm only once the line is seen high again, so the tail of a
               // frame cannot be taken for a new start bit.
               if (strobe && sample_bit) begin
                  state_d = ST_IDLE;
               end
            end
         endcase
      end
   end

   // State registers, all cleared immediately when reset_in drops
   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         sclk_sync_q   <= 3'd0;
         sdata_sync_q  <= 2'd0;
         state_q       <= ST_IDLE;
         shift_q       <= '0;
         bit_cnt_q     <= 6'd0;
         timer_q       <= 13'd0;
         frame_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
         err_code_q    <= 3'd0;
         frame_reg_q   <= 16'd0;
         frame_data_q  <= 16'd0;
         frame_cnt_q   <= 16'd0;
      end else begin
         sclk_sync_q   <= sclk_sync_d;
         sdata_sync_q  <= sdata_sync_d;
         state_q       <= state_d;
         shift_q       <= shift_d;
         bit_cnt_q     <= bit_cnt_d;
         timer_q       <= timer_d;
         frame_valid_q <= frame_valid_d;
         frame_err_q   <= frame_err_d;
         err_code_q    <= err_code_d;
         frame_reg_q   <= frame_reg_d;
         frame_data_q  <= frame_data_d;
         frame_cnt_q   <= frame_cnt_d;
      end
   end

endmodule

// File: tb/tb_ether_frame_rx.sv
// Bench for ether_frame_rx. A bit-banged transmitter drives the pins.
// A frame-level model predicts the cycle and content of every pulse and the
// held fields. A compare process checks the DUT against the model on every cycle.
module tb_ether_frame_rx;

   logic        clk_in   = 1'b0;
   logic        reset_in = 1'b0;
   logic        sclk_in  = 1'b1;
   logic        sdata_in = 1'b1;
   logic        rx_en    = 1'b0;
   logic        busy;
   logic        frame_valid;
   logic [15:0] frame_reg;
   logic [15:0] frame_data;
   logic        frame_err;
   logic [2:0]  err_code;
   logic [15:0] frame_cnt;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Model state: held fields plus the single outstanding predicted pulse
   logic [15:0] m_reg, m_data, m_cnt;
   logic [2:0]  m_code;
   int          pend_cyc  = -1;
   int          pend_kind = 0;
   logic [15:0] pend_reg, pend_data;

   // Observed pulse statistics for the literal checks
   int valid_seen   = 0;
   int err_seen     = 0;
   int last_err_cyc = -1;
   int last_rise    = 0;

   ether_frame_rx dut (
      .clk_in      (clk_in),
      .reset_in    (reset_in),
      .sclk_in     (sclk_in),
      .sdata_in    (sdata_in),
      .rx_en       (rx_en),
      .busy        (busy),
      .frame_valid (frame_valid),
      .frame_reg   (frame_reg),
      .frame_data  (frame_data),
      .frame_err   (frame_err),
      .err_code    (err_code),
      .frame_cnt   (frame_cnt)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_reg     = 16'd0;
      m_data    = 16'd0;
      m_cnt     = 16'd0;
      m_code    = 3'd0;
      pend_cyc  = -1;
      pend_kind = 0;
   endtask

   // Advance n clock edges, then sit 2 time units past the edge to drive pins
   task automatic step(input int n);
      repeat (n) @(posedge clk_in);
      #2;
   endtask

   function automatic logic [57:0] make_frame(input logic [15:0] r, input logic [15:0] d);
      return {17'h03000, 2'b11, r, 2'b11, d, 5'b11000};
   endfunction

   // Outcome of a complete frame: 0 good, else the framing error code
   function automatic int classify(input logic [57:0] f);
      if (f[57:41] != 17'h03000) return 1;
      if ((f[40:39] != 2'b11) || (f[22:21] != 2'b11)) return 2;
      if (f[4:0] != 5'b11000) return 3;
      return 0;
   endfunction

   // Send the first nbits of f MSB first, data changing on the sclk fall
   task automatic send_bits(input logic [57:0] f, input int nbits, input int half);
      for (int i = 0; i < nbits; i++) begin
         step(half);
         sclk_in  = 1'b0;
         sdata_in = f[57-i];
         step(half);
         sclk_in   = 1'b1;
         last_rise = cyc;
      end
   endtask

   task automatic send_idle(input int n, input int half);
      logic [57:0] ones;
      ones = '1;
      send_bits(ones, n, half);
   endtask

   // The final strobe is consumed 3 edges after the pin rise; the pulse follows one edge later
   task automatic send_frame(input logic [57:0] f, input int half);
      send_bits(f, 58, half);
      pend_kind = classify(f);
      pend_reg  = f[38:23];
      pend_data = f[20:5];
      pend_cyc  = last_rise + 4;
      step(half);
   endtask

   task automatic apply_reset();
      reset_in = 1'b0;
      sclk_in  = 1'b1;
      sdata_in = 1'b1;
      model_reset();
      step(3);
      reset_in   = 1'b1;
      valid_seen = 0;
      err_seen   = 0;
      step(4);
   endtask

   // Compare every cycle: pulses must occur exactly when predicted, held fields must match
   initial begin
      model_reset();
      forever begin
         @(posedge clk_in);
         #1;
         if (cyc == pend_cyc) begin
            if (pend_kind == 0) begin
               m_reg  = pend_reg;
               m_data = pend_data;
               m_cnt  = m_cnt + 16'd1;
            end else begin
               m_code = 3'(pend_kind);
            end
         end
         if (frame_valid === 1'b1) valid_seen++;
         if (frame_err === 1'b1) begin
            err_seen++;
            last_err_cyc = cyc;
         end
         check_output("frame_valid", 32'(frame_valid), 32'((cyc == pend_cyc) && (pend_kind == 0)));
         check_output("frame_err", 32'(frame_err), 32'((cyc == pend_cyc) && (pend_kind != 0)));
         check_output("frame_reg", 32'(frame_reg), 32'(m_reg));
         check_output("frame_data", 32'(frame_data), 32'(m_data));
         check_output("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
         check_output("err_code", 32'(err_code), 32'(m_code));
      end
   end

   // Directed scenarios with hand-computed literal expectations
   initial begin
      logic [57:0] f;
      int          t_rise;

      // Reset state
      step(2);
      check_output("reset_busy", 32'(busy), 32'd0);
      check_output("reset_cnt", 32'(frame_cnt), 32'd0);
      check_output("reset_code", 32'(err_code), 32'd0);
      apply_reset();
      rx_en = 1'b1;
      step(4);

      // Good frame at 320 clocks per bit
      $display("[TB] scenario 1: single good frame");
      f = 58'b00011000000000000_11_0000000000001111_11_0000000000000000_11000;
      send_idle(1, 160);
      send_frame(f, 160);
      step(10);
      check_output("t1_reg", 32'(frame_reg), 32'h000F);
      check_output("t1_data", 32'(frame_data), 32'h0000);
      check_output("t1_cnt", 32'(frame_cnt), 32'd1);
      check_output("t1_valid_seen", 32'(valid_seen), 32'd1);
      check_output("t1_busy", 32'(busy), 32'd0);

      // Back-to-back frames separated by two idle-high bits
      $display("[TB] scenario 2: back-to-back frames");
      apply_reset();
      send_idle(1, 8);
      send_frame(make_frame(16'h0003, 16'hFFFC), 8);
      send_idle(2, 8);
      send_frame(make_frame(16'h0003, 16'hFFC3), 8);
      step(10);
      check_output("t2_data", 32'(frame_data), 32'hFFC3);
      check_output("t2_cnt", 32'(frame_cnt), 32'd2);
      check_output("t2_valid_seen", 32'(valid_seen), 32'd2);
      check_output("t2_err_seen", 32'(err_seen), 32'd0);

      // Broken first separator
      $display("[TB] scenario 3: separator error");
      f = make_frame(16'h7777, 16'h8888);
      f[39] = 1'b0;
      send_idle(1, 8);
      send_frame(f, 8);
      step(10);
      check_output("t3_code", 32'(err_code), 32'd2);
      check_output("t3_reg", 32'(frame_reg), 32'h0003);
      check_output("t3_data", 32'(frame_data), 32'hFFC3);
      check_output("t3_cnt", 32'(frame_cnt), 32'd2);
      check_output("t3_err_seen", 32'(err_seen), 32'd1);

      // sclk stops after 30 bits
      $display("[TB] scenario 4: timeout");
      send_idle(1, 8);
      send_bits(make_frame(16'h1234, 16'h5678), 30, 8);
      t_rise    = last_rise;
      pend_kind = 4;
      pend_cyc  = t_rise + 2 + 4096;
      step(4200);
      check_output("t4_code", 32'(err_code), 32'd4);
      check_output("t4_err_cycle", 32'(last_err_cyc - t_rise), 32'd4098);
      check_output("t4_busy", 32'(busy), 32'd0);
      send_idle(1, 8);
      send_frame(make_frame(16'h1234, 16'h5678), 8);
      step(10);
      check_output("t4_reg", 32'(frame_reg), 32'h1234);
      check_output("t4_cnt", 32'(frame_cnt), 32'd3);

      // rx_en dropped mid-frame
      $display("[TB] scenario 5: receiver disabled mid-frame");
      send_idle(1, 8);
      send_bits(make_frame(16'hAAAA, 16'h5555), 20, 8);
      step(2);
      check_output("t5_busy_mid", 32'(busy), 32'd1);
      rx_en = 1'b0;
      step(3);
      check_output("t5_busy_off", 32'(busy), 32'd0);
      rx_en = 1'b1;
      step(2);
      send_idle(1, 8);
      send_frame(make_frame(16'h0F0F, 16'hF0F0), 8);
      step(10);
      check_output("t5_data", 32'(frame_data), 32'hF0F0);
      check_output("t5_cnt", 32'(frame_cnt), 32'd4);
      check_output("t5_valid_seen", 32'(valid_seen), 32'd4);
      check_output("t5_err_seen", 32'(err_seen), 32'd2);

      // Reset asserted mid-frame clears outputs without a clock edge
      $display("[TB] scenario 6: reset mid-frame");
      send_idle(1, 8);
      send_bits(make_frame(16'hBEEF, 16'hCAFE), 40, 8);
      step(1);
      reset_in = 1'b0;
      model_reset();
      #1;
      check_output("t6_async_busy", 32'(busy), 32'd0);
      check_output("t6_async_reg", 32'(frame_reg), 32'd0);
      check_output("t6_async_data", 32'(frame_data), 32'd0);
      check_output("t6_async_cnt", 32'(frame_cnt), 32'd0);
      check_output("t6_async_pulses", 32'({frame_valid, frame_err}), 32'd0);
      sclk_in  = 1'b1;
      sdata_in = 1'b1;
      step(4);
      reset_in = 1'b1;
      step(4);
      send_idle(1, 8);
      send_frame(make_frame(16'hBEEF, 16'hCAFE), 8);
      step(10);
      check_output("t6_reg", 32'(frame_reg), 32'hBEEF);
      check_output("t6_cnt", 32'(frame_cnt), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
